// File: rtl/toast_dmem_bridge.sv
// toast_dmem_bridge
//   Converts the MEM stage's single-cycle data-memory port into a req/gnt/rvalid
//   system bus that may insert any number of wait states. The upstream pipeline
//   is held with stall_o until the access finishes. A bus error or a timeout is
//   reported as a one-cycle err_o pulse in the cycle the access completes.
//
// Ports
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   DMEM_*_i               access from the MEM stage (address, byte enables,
//                          store data, load request)
//   DMEM_rd_data_o         registered load data
//   stall_o                hold all upstream pipeline registers
//   err_o                  one-cycle error/timeout pulse
//   bus_*_o                registered request (req, we, addr, be, wdata)
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i   bus responses
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no access in flight; an access on the inputs is launched
// REQ    | bus_req_o high, fields held until the bus grants
// WAIT_R | read granted, waiting for rvalid
// DONE   | one cycle: stall released, err_o valid, pipeline advances

module toast_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] DMEM_addr_i,
  input  logic [3:0]  DMEM_wr_byte_en_i,
  input  logic [31:0] DMEM_wr_data_i,
  input  logic        DMEM_rd_en_i,
  output logic [31:0] DMEM_rd_data_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  // The counter holds the number of cycles already spent in REQ/WAIT_R, so the
  // current cycle is the last one allowed once it reaches TIMEOUT_CYCLES-1.
  // Using >= keeps the abort armed after a grant that won against the limit.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic is_wr;
  logic access;
  logic timeout;

  assign is_wr   = |DMEM_wr_byte_en_i;
  assign access  = DMEM_rd_en_i | is_wr;
  assign timeout = (cnt_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;   // only set on the transition into DONE -> one-cycle pulse

    case (state_q)
      IDLE: begin
        if (access) begin
          req_d   = 1'b1;
          we_d    = is_wr;
          addr_d  = DMEM_addr_i;
          be_d    = is_wr ? DMEM_wr_byte_en_i : 4'b1111;
          wdata_d = DMEM_wr_data_i;
          cnt_d   = 16'd0;
          state_d = REQ;
        end
      end

      REQ: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            err_d   = bus_err_i;
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = 32'd0;
        end
      end

      WAIT_R: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus_rvalid_i) begin
          rdata_d = bus_err_i ? 32'd0 : bus_rdata_i;
          err_d   = bus_err_i;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // The finished access is still on the inputs here; never relaunch it.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stall is released while reset is asserted even if the MEM stage still
  // presents an access.
  assign stall_o = resetn_i & (((state_q == IDLE) & access) |
                               (state_q == REQ) | (state_q == WAIT_R));

  assign DMEM_rd_data_o = rdata_q;
  assign err_o          = err_q;
  assign bus_req_o      = req_q;
  assign bus_we_o       = we_q;
  assign bus_addr_o     = addr_q;
  assign bus_be_o       = be_q;
  assign bus_wdata_o    = wdata_q;

endmodule

// File: tb/tb_toast_dmem_bridge.sv
module tb_toast_dmem_bridge;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic [31:0] DMEM_addr_i = '0;
  logic [3:0]  DMEM_wr_byte_en_i = '0;
  logic [31:0] DMEM_wr_data_i = '0;
  logic        DMEM_rd_en_i = 1'b0;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;

  logic [31:0] DMEM_rd_data_o, bus_addr_o, bus_wdata_o;
  logic        stall_o, err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;

  logic [31:0] to_rd_data, to_addr, to_wdata;
  logic        to_stall, to_err, to_req, to_we;
  logic [3:0]  to_be;

  always #5 clk_i = ~clk_i;

  toast_dmem_bridge u_dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .DMEM_addr_i(DMEM_addr_i), .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i),
    .DMEM_wr_data_i(DMEM_wr_data_i), .DMEM_rd_en_i(DMEM_rd_en_i),
    .DMEM_rd_data_o(DMEM_rd_data_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  // Second instance with a short timeout, sharing all inputs.
  toast_dmem_bridge #(.TIMEOUT_CYCLES(4)) u_to (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .DMEM_addr_i(DMEM_addr_i), .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i),
    .DMEM_wr_data_i(DMEM_wr_data_i), .DMEM_rd_en_i(DMEM_rd_en_i),
    .DMEM_rd_data_o(to_rd_data), .stall_o(to_stall), .err_o(to_err),
    .bus_req_o(to_req), .bus_we_o(to_we), .bus_addr_o(to_addr),
    .bus_be_o(to_be), .bus_wdata_o(to_wdata),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  typedef struct {
    logic        rd_en;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gw;         // REQ cycles before gnt
    int          rv;         // cycles after gnt until rvalid (reads)
    logic        berr;
    int          exp_stalls;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd = '0;
  int          to_stalls;
  logic        to_err_done;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    resetn_i = 1'b0;
    DMEM_rd_en_i = 1'b0; DMEM_wr_byte_en_i = '0; DMEM_addr_i = '0; DMEM_wr_data_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;
    last_rd = '0;
    sb_q.delete();
  endtask

  task automatic run_access(input vec_t v, input bit chain, input string name);
    bit          wr, granted, fin;
    int          stalls, reqs, k;
    logic [31:0] exp_rd;
    exp_t        e;
    wr = |v.be;
    exp_rd = wr ? last_rd : (v.berr ? 32'h0 : v.rdata);
    last_rd = exp_rd;
    @(posedge clk_i); #1;
    DMEM_rd_en_i = v.rd_en; DMEM_wr_byte_en_i = v.be;
    DMEM_addr_i = v.addr; DMEM_wr_data_i = v.wdata;
    sb_q.push_back('{err: v.exp_err, rd: exp_rd});
    stalls = 0; reqs = 0; k = 0; granted = 0; fin = 0; to_stalls = 0; to_err_done = 1'bx;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      if (cyc > 0) begin @(posedge clk_i); #1; end
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      if (bus_req_o) begin
        if (reqs == v.gw) begin
          bus_gnt_i = 1'b1; granted = 1;
          if (wr) bus_err_i = v.berr;
        end
        reqs++;
      end else if (granted && !wr) begin
        k++;
        if (k == v.rv) begin
          bus_rvalid_i = 1'b1; bus_err_i = v.berr; bus_rdata_i = v.rdata;
        end
      end
      @(negedge clk_i);
      if (cyc == 0) chk({name, " req_idle"}, 96'(bus_req_o), 96'(0));
      if (cyc == 1) chk({name, " req_rise"}, 96'(bus_req_o), 96'(1));
      if (bus_req_o)
        chk({name, " bus_fields"},
            96'({bus_we_o, bus_be_o, bus_addr_o, wr ? bus_wdata_o : 32'h0}),
            96'({wr, wr ? v.be : 4'hF, v.addr, wr ? v.wdata : 32'h0}));
      if (to_stall) to_stalls++;
      if (stall_o) stalls++;
      else if (cyc > 0) begin
        fin = 1;
        to_err_done = to_err;
        if (sb_q.size() == 0) chk({name, " sb_empty"}, 96'(1), 96'(0));
        else begin
          e = sb_q.pop_front();
          chk({name, " done_err"}, 96'(err_o), 96'(e.err));
          chk({name, " done_rdata"}, 96'(DMEM_rd_data_o), 96'(e.rd));
        end
        chk({name, " done_req"}, 96'(bus_req_o), 96'(0));
      end
    end
    if (!fin) chk({name, " completion_timeout"}, 96'(0), 96'(1));
    chk({name, " stall_cycles"}, 96'(stalls), 96'(v.exp_stalls));
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    if (!chain) begin
      @(posedge clk_i); #1;
      DMEM_rd_en_i = 1'b0; DMEM_wr_byte_en_i = '0; DMEM_addr_i = '0; DMEM_wr_data_i = '0;
      @(negedge clk_i);
      chk({name, " after_done"}, 96'({err_o, stall_o, bus_req_o, DMEM_rd_data_o}),
          96'({1'b0, 1'b0, 1'b0, last_rd}));
    end
  endtask

  initial begin
    int n;
    bit fin;
    int treq, tst;
    //            rd_en be     addr          wdata         rdata         gw rv berr stalls err
    vecs[0] = '{1'b0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1, 1'b0, 2, 1'b0};
    vecs[1] = '{1'b1, 4'h0, 32'h0000_0104, 32'h0,         32'h1234_5678, 3, 2, 1'b0, 7, 1'b0};
    vecs[2] = '{1'b0, 4'h4, 32'h0000_0108, 32'h00AB_0000, 32'h0,        0, 1, 1'b1, 2, 1'b1};
    vecs[3] = '{1'b1, 4'h0, 32'h0000_010C, 32'h0,         32'hA5A5_A5A5, 0, 1, 1'b0, 3, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 32'h0000_0110, 32'h0,         32'hFFFF_FFFF, 1, 1, 1'b1, 4, 1'b1};
    vecs[5] = '{1'b1, 4'h3, 32'h0000_0114, 32'h0000_BEEF, 32'h7777_7777, 2, 1, 1'b0, 4, 1'b0};
    vecs[6] = '{1'b0, 4'hC, 32'h0000_0118, 32'hCAFE_0000, 32'h0,        5, 1, 1'b0, 7, 1'b0};

    do_reset();
    @(negedge clk_i);
    chk("reset_state",
        96'({stall_o, err_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}), 96'(0));
    chk("reset_rdata", 96'(DMEM_rd_data_o), 96'(0));

    for (int i = 0; i < 7; i++) run_access(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Back-to-back SW then LW with zero wait states.
    run_access('{1'b0, 4'hF, 32'h0000_0200, 32'h0BAD_F00D, 32'h0, 0, 1, 1'b0, 2, 1'b0}, 1'b1, "b2b_sw");
    run_access('{1'b1, 4'h0, 32'h0000_0204, 32'h0, 32'h5555_AAAA, 0, 1, 1'b0, 3, 1'b0}, 1'b0, "b2b_lw");

    // Reset while a read is in WAIT_R; the late rvalid must be ignored.
    @(posedge clk_i); #1;
    DMEM_rd_en_i = 1'b1; DMEM_addr_i = 32'h0000_0300;
    @(posedge clk_i); #1; bus_gnt_i = 1'b1;
    @(posedge clk_i); #1; bus_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_stall", 96'({stall_o, bus_req_o}), 96'({1'b1, 1'b0}));
    resetn_i = 1'b0; #1;
    chk("rst_imm", 96'({stall_o, bus_req_o, err_o, DMEM_rd_data_o}), 96'(0));
    DMEM_rd_en_i = 1'b0; DMEM_addr_i = '0; last_rd = '0;
    @(negedge clk_i); resetn_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    chk("rst_late_rvalid", 96'({stall_o, bus_req_o, err_o, DMEM_rd_data_o}), 96'(0));
    @(posedge clk_i); #1; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk_i);
    chk("rst_late_hold", 96'({stall_o, err_o, DMEM_rd_data_o}), 96'(0));
    run_access('{1'b1, 4'h0, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 0, 1, 1'b0, 3, 1'b0}, 1'b0, "rst_next");

    // Short-timeout instance: gnt/rvalid on the limit cycle win over the abort.
    do_reset();
    run_access('{1'b1, 4'h0, 32'h0000_0400, 32'h0, 32'h600D_F00D, 3, 1, 1'b0, 6, 1'b0}, 1'b0, "to_prio");
    chk("to_prio_stalls", 96'(to_stalls), 96'(6));
    chk("to_prio_err", 96'(to_err_done), 96'(0));
    chk("to_prio_rdata", 96'(to_rd_data), 96'(32'h600D_F00D));

    // Read never granted: aborted after 4 REQ cycles.
    @(posedge clk_i); #1;
    DMEM_rd_en_i = 1'b1; DMEM_addr_i = 32'h0000_0500;
    fin = 0; treq = 0; tst = 0;
    for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
      if (cyc > 0) begin @(posedge clk_i); #1; end
      @(negedge clk_i);
      if (to_req) treq++;
      if (to_stall) tst++;
      else if (cyc > 0) begin
        fin = 1;
        chk("to_err_pulse", 96'(to_err), 96'(1));
        chk("to_rdata_zero", 96'(to_rd_data), 96'(0));
      end
    end
    if (!fin) chk("to_completion_timeout", 96'(0), 96'(1));
    chk("to_req_cycles", 96'(treq), 96'(4));
    chk("to_stall_cycles", 96'(tst), 96'(5));
    @(posedge clk_i); #1;
    DMEM_rd_en_i = 1'b0; DMEM_addr_i = '0;
    @(negedge clk_i);
    chk("to_after", 96'({to_err, to_stall, to_req}), 96'(0));

    do_reset();
    n = sb_q.size();
    chk("sb_drained", 96'(n), 96'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
